// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// trap causes and the reset value of the instruction register.
package core_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_ILLEGAL    = 2'd0,
        CAUSE_MISALIGNED = 2'd1,
        CAUSE_TIMEOUT    = 2'd2,
        CAUSE_ECALL      = 2'd3
    } trap_cause_t;

    // Opcodes whose second ALU operand is the immediate.
    function automatic logic uses_imm(input logic [6:0] opc);
        return (opc == OPC_OP_IMM) || (opc == OPC_LOAD) || (opc == OPC_STORE) ||
               (opc == OPC_JALR) || (opc == OPC_LUI) || (opc == OPC_AUIPC);
    endfunction

endpackage

// File: rtl/branch_unit.sv
// Combinational branch-condition evaluation from funct3 and the ALU flags.
module branch_unit (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       illegal
);

    // Select the compare flag for this funct3; 010/011 have no branch meaning
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencer: owns PC, IR, the control FSM and the memory
// request handshakes, and strobes the datapath one phase at a time.
//
// Handshake: a request (imem_req / dmem_req) is raised from state alone and
// held, with its address/qualifier stable, until the cycle the matching
// ready is sampled high at a rising edge; that edge completes the transfer.
// No output is a combinational function of either ready input; retire is
// registered and therefore pulses the cycle after the completing edge,
// together with the updated pc.
module multicycle_sequencer
    import core_pkg::*;
#(
    parameter int unsigned       XLEN        = 32,
    parameter logic [XLEN-1:0]   RESET_PC    = '0,
    parameter int unsigned       MEM_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    input  logic            alu_zero,
    input  logic            alu_lt,
    input  logic            alu_ltu,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic            alu_src,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            retire,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output state_t          fsm_state
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [31:0]     cnt_q, cnt_d;
    trap_cause_t     cause_q, cause_d;
    logic            retire_q, retire_d;

    logic [6:0]      opcode;
    logic            br_taken, br_illegal;
    logic [XLEN-1:0] pc_plus4, next_pc;
    logic            target_misaligned;
    logic            timeout_hit;

    assign opcode   = ir_q[6:0];
    assign pc_plus4 = pc_q + XLEN'(4);

    branch_unit u_branch (
        .funct3  (ir_q[14:12]),
        .zero    (alu_zero),
        .lt      (alu_lt),
        .ltu     (alu_ltu),
        .taken   (br_taken),
        .illegal (br_illegal)
    );

    // Candidate pc for the instruction in IR, checked for alignment before use
    always_comb begin
        next_pc = pc_plus4;
        case (opcode)
            OPC_BRANCH: if (br_taken) next_pc = branch_target;
            OPC_JAL:    next_pc = branch_target;
            OPC_JALR:   next_pc = jalr_target & ~XLEN'(1);
            default:    next_pc = pc_plus4;
        endcase
    end

    assign target_misaligned = |next_pc[1:0];
    assign timeout_hit = (MEM_TIMEOUT != 0) && ((cnt_q + 32'd1) >= MEM_TIMEOUT);

    // Next-state, pc/IR updates and per-phase strobes
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        cause_d    = cause_q;
        retire_d   = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;

        if (state_q inside {S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK}) begin
            alu_src    = uses_imm(opcode);
            mem_to_reg = (opcode == OPC_LOAD);
        end

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_TRAP;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                case (opcode)
                    OPC_BRANCH: begin
                        if (br_illegal) begin
                            cause_d = CAUSE_ILLEGAL;
                            state_d = S_TRAP;
                        end else if (target_misaligned) begin
                            cause_d = CAUSE_MISALIGNED;
                            state_d = S_TRAP;
                        end else begin
                            pc_d     = next_pc;
                            retire_d = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end
                    OPC_LOAD, OPC_STORE: state_d = S_MEM;
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
                        state_d = S_WRITEBACK;
                    OPC_SYSTEM: begin
                        cause_d = CAUSE_ECALL;
                        state_d = S_TRAP;
                    end
                    default: begin
                        cause_d = CAUSE_ILLEGAL;
                        state_d = S_TRAP;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OPC_STORE);
                if (dmem_ready) begin
                    if (opcode != OPC_STORE) begin
                        state_d = S_WRITEBACK;
                    end else if (target_misaligned) begin
                        cause_d = CAUSE_MISALIGNED;
                        state_d = S_TRAP;
                    end else begin
                        pc_d     = next_pc;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_TRAP;
                end
            end
            S_WRITEBACK: begin
                if (target_misaligned) begin
                    cause_d = CAUSE_MISALIGNED;
                    state_d = S_TRAP;
                end else begin
                    reg_write = 1'b1;
                    pc_d      = next_pc;
                    retire_d  = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Wait counter runs only while a request stays pending in the same state
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && (state_q == S_FETCH || state_q == S_MEM))
            cnt_d = cnt_q + 32'd1;
    end

    // State, PC, IR, wait counter, trap cause and retire pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= NOP;
            cnt_q    <= '0;
            cause_q  <= CAUSE_ILLEGAL;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            retire_q <= retire_d;
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign instr      = ir_q;
    assign retire     = retire_q;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed program, randomized instruction
// stream against an ISA-level next-pc model, trap sources and bus timeout.
module tb_multicycle_sequencer;
    import core_pkg::*;

    localparam int N_RAND = 200;

    logic        clk, reset;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
    logic [31:0] imem_addr, imem_rdata, instr, pc;
    logic        alu_zero, alu_lt, alu_ltu;
    logic [31:0] branch_target, jalr_target;
    logic        alu_src, mem_to_reg, reg_write, retire, trap;
    logic [1:0]  trap_cause;
    state_t      fsm_state;

    int          tests = 0;
    int          fails = 0;
    int          retired = 0;
    int          rw_seen = 0;
    logic        we_seen = 1'b0;
    logic [31:0] model_pc;
    // {next pc, reg_write expected, store expected, mem_to_reg expected}
    logic [34:0] exp_q[$];

    multicycle_sequencer #(.XLEN(32), .RESET_PC(32'h0), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .pc(pc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .branch_target(branch_target), .jalr_target(jalr_target),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .retire(retire), .trap(trap), .trap_cause(trap_cause), .fsm_state(fsm_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Time limit
    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] pack_exp(input logic [31:0] p, input logic rw, input logic we,
                                             input logic m2r);
        return {p, rw, we, m2r};
    endfunction

    // ISA-level next pc for one retired instruction
    function automatic logic [31:0] ref_next_pc(input logic [6:0] opc, input logic [2:0] f3,
                                                input logic z, input logic lt, input logic ltu,
                                                input logic [31:0] p, input logic [31:0] bt,
                                                input logic [31:0] jt);
        logic taken;
        case (f3)
            3'd0:    taken = z;
            3'd1:    taken = !z;
            3'd4:    taken = lt;
            3'd5:    taken = !lt;
            3'd6:    taken = ltu;
            default: taken = !ltu;
        endcase
        if (opc == OPC_BRANCH) return taken ? bt : p + 32'd4;
        if (opc == OPC_JAL) return bt;
        if (opc == OPC_JALR) return {jt[31:1], 1'b0};
        return p + 32'd4;
    endfunction

    // Monitor: per-instruction strobes are accumulated and checked at retire
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                rw_seen = 0;
                we_seen = 1'b0;
            end else begin
                if (reg_write) begin
                    rw_seen++;
                    if (exp_q.size() > 0) begin
                        e = exp_q[0];
                        check("mem_to_reg", 32'(mem_to_reg), 32'(e[0]));
                    end
                end
                if (dmem_req && dmem_we) we_seen = 1'b1;
                if (retire) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL retire_unexpected: retire at pc 0x%08h, nothing expected", pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("retire_pc", pc, e[34:3]);
                        check("reg_write_count", 32'(rw_seen), 32'(e[2]));
                        check("store_seen", 32'(we_seen), 32'(e[1]));
                        retired++;
                    end
                    rw_seen = 0;
                    we_seen = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = 32'h0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        branch_target = 32'h0; jalr_target = 32'h0;
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_trap", 32'(trap), 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Fetch one instruction, serve any data access after dly wait cycles,
    // and return when it retires or traps.
    task automatic run_instr(input logic [31:0] ins, input logic z, input logic lt, input logic ltu,
                             input logic [31:0] bt, input logic [31:0] jt, input int dly,
                             output int req_wait, output int lat, output int dreq, output logic done);
        int   dcnt;
        logic fin;
        req_wait = 0; lat = 0; dreq = 0; done = 1'b0; dcnt = 0; fin = 1'b0;
        alu_zero = z; alu_lt = lt; alu_ltu = ltu;
        branch_target = bt; jalr_target = jt;
        while (!imem_req && req_wait < 20) begin
            @(negedge clk);
            req_wait++;
        end
        if (imem_req) begin
            imem_rdata = ins;
            imem_ready = 1'b1;
            lat = 1;
            @(negedge clk);
            imem_ready = 1'b0;
            lat = 2;
            for (int i = 0; i < 40 && !fin; i++) begin
                if (retire || trap) begin
                    done = retire;
                    fin  = 1'b1;
                end else begin
                    dmem_ready = 1'b0;
                    if (dmem_req) begin
                        dreq++;
                        dmem_ready = (dcnt == dly);
                        dcnt++;
                    end
                    @(negedge clk);
                    lat++;
                end
            end
            dmem_ready = 1'b0;
        end
    endtask

    task automatic issue_random();
        logic [31:0] r, ins, bt, jt, np;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        z, lt, ltu, rw, we, m2r;
        int          k, idx;
        check("fetch_addr", imem_addr, model_pc);
        r   = $urandom;
        z   = 1'($urandom_range(0, 1));
        lt  = 1'($urandom_range(0, 1));
        ltu = 1'($urandom_range(0, 1));
        f3  = r[14:12];
        rw  = 1'b1; we = 1'b0; m2r = 1'b0;
        k   = $urandom_range(0, 9);
        case (k)
            0: opc = OPC_OP_IMM;
            1: opc = OPC_OP;
            2: opc = OPC_LUI;
            3: opc = OPC_AUIPC;
            4, 5: begin
                opc = OPC_BRANCH;
                idx = $urandom_range(0, 5);
                f3  = (idx < 2) ? 3'(idx) : 3'(idx + 2);
                rw  = 1'b0;
            end
            6: begin opc = OPC_LOAD; m2r = 1'b1; end
            7: begin opc = OPC_STORE; rw = 1'b0; we = 1'b1; end
            8: opc = OPC_JAL;
            default: opc = OPC_JALR;
        endcase
        bt  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        jt  = $urandom & 32'hFFFF_FFFD;
        ins = {r[31:15], f3, r[11:7], opc};
        np  = ref_next_pc(opc, f3, z, lt, ltu, model_pc, bt, jt);
        exp_q.push_back(pack_exp(np, rw, we, m2r));
        alu_zero = z; alu_lt = lt; alu_ltu = ltu;
        branch_target = bt; jalr_target = jt;
        imem_rdata = ins;
        imem_ready = 1'b1;
        model_pc = np;
    endtask

    task automatic trap_test(input string name, input logic [31:0] ins, input logic [31:0] jt,
                             input logic [1:0] cause);
        int   rw_, lat, dreq;
        logic done;
        do_reset();
        run_instr(ins, 1'b0, 1'b0, 1'b0, 32'h0, jt, 0, rw_, lat, dreq, done);
        check({name, "_retired"}, 32'(done), 32'h0);
        check({name, "_trap"}, 32'(trap), 32'h1);
        check({name, "_cause"}, 32'(trap_cause), 32'(cause));
        check({name, "_pc"}, pc, 32'h0);
        repeat (3) @(negedge clk);
        check({name, "_sticky"}, 32'(trap), 32'h1);
        check({name, "_quiet"}, 32'({imem_req, dmem_req, reg_write}), 32'h0);
    endtask

    // Stimulus
    initial begin
        int   req_wait, lat, dreq, cyc, issued, base, iwait, dwait, n;
        logic done;

        reset = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = 32'h0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        branch_target = 32'h0; jalr_target = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(fsm_state), 32'(S_IDLE));
        check("rst_strobes", 32'({dmem_req, dmem_we, reg_write, retire, alu_src, mem_to_reg}), 32'h0);
        check("rst_cause", 32'(trap_cause), 32'h0);
        reset = 1'b0;

        // ADDI x1, x0, 1 at address 0
        exp_q.push_back(pack_exp(32'h4, 1'b1, 1'b0, 1'b0));
        run_instr(32'h0010_0093, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, req_wait, lat, dreq, done);
        check("first_req_delay", 32'(req_wait), 32'd1);
        check("addi_retire_cycle", 32'(lat), 32'd5);
        check("addi_done", 32'(done), 32'h1);

        // BEQ taken to 0x40, then BEQ not taken
        exp_q.push_back(pack_exp(32'h40, 1'b0, 1'b0, 1'b0));
        run_instr(32'h0000_0063, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 0, req_wait, lat, dreq, done);
        check("beq_taken_done", 32'(done), 32'h1);
        exp_q.push_back(pack_exp(32'h44, 1'b0, 1'b0, 1'b0));
        run_instr(32'h0000_0063, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 0, req_wait, lat, dreq, done);
        check("beq_not_taken_done", 32'(done), 32'h1);

        // LW with three wait states, then SW with one
        exp_q.push_back(pack_exp(32'h48, 1'b1, 1'b0, 1'b1));
        run_instr(32'h0000_2003, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3, req_wait, lat, dreq, done);
        check("lw_dmem_req_cycles", 32'(dreq), 32'd4);
        exp_q.push_back(pack_exp(32'h4C, 1'b0, 1'b1, 1'b0));
        run_instr(32'h0000_2023, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1, req_wait, lat, dreq, done);
        check("sw_dmem_req_cycles", 32'(dreq), 32'd2);
        check("sw_done", 32'(done), 32'h1);

        // Random instruction stream with random wait states
        do_reset();
        model_pc = 32'h0;
        issued   = 0;
        base     = retired;
        iwait    = $urandom_range(0, 3);
        dwait    = $urandom_range(0, 3);
        cyc      = 0;
        while ((retired - base) < N_RAND && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            if (imem_req && issued < N_RAND) begin
                if (iwait == 0) begin
                    issue_random();
                    issued++;
                    iwait = $urandom_range(0, 3);
                end else begin
                    iwait--;
                end
            end
            if (dmem_req) begin
                if (dwait == 0) begin
                    dmem_ready = 1'b1;
                    dwait = $urandom_range(0, 3);
                end else begin
                    dwait--;
                end
            end
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        check("random_retired", 32'(retired - base), 32'(N_RAND));
        check("random_queue_drained", 32'(exp_q.size()), 32'h0);
        check("random_no_trap", 32'(trap), 32'h0);

        // Trap sources
        trap_test("illegal_opcode", 32'h0000_007F, 32'h0, 2'd0);
        trap_test("illegal_branch", 32'h0000_2063, 32'h0, 2'd0);
        trap_test("jalr_misaligned", 32'h0000_0067, 32'h102, 2'd1);
        trap_test("ecall", 32'h0000_0073, 32'h0, 2'd3);

        // Fetch never accepted: bus timeout after four wait cycles
        do_reset();
        n = 0;
        for (int i = 0; i < 20 && !trap; i++) begin
            @(negedge clk);
            if (imem_req) n++;
        end
        check("timeout_req_cycles", 32'(n), 32'd4);
        check("timeout_trap", 32'(trap), 32'h1);
        check("timeout_cause", 32'(trap_cause), 32'd2);
        check("timeout_req_dropped", 32'(imem_req), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("timeout_reset_pc", pc, 32'h0);
        check("timeout_reset_trap", 32'(trap), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
